can_frame_sequencer: RTL and testbench
======================================

Name: can_frame_sequencer

Overview:
- Bit-level receive controller for the CAN decoder.
- Consumes one sampled bus bit per sample-point strobe, removes stuff bits, and walks the frame fields of base (11-bit ID) and extended (29-bit ID) frames.
- Generates field captures (ID, RTR/IDE/EDL, DLC, data bytes), checks CRC15 and form rules, and reports frame-done or error.
- Downstream frame-type and payload blocks take their strobes and values from this block.

Parameters:
- MAX_BYTES, 8, maximum data bytes per frame; DLC values above 8 are clamped to this.
- IDLE_BITS, 11, consecutive recessive bits required to declare the bus idle after an error or at power-up.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- sp  in  1  sample-point strobe, one clk wide.
- rx_bit  in  1  bus value sampled at sp (0 = dominant).
- state  out  5  current field state, encoded per package.
- frame_id  out  29  captured ID; base frames use [28:18], with [17:0] = 0.
- ide  out  1  extended-frame flag.
- rtr  out  1  remote-request flag.
- edl  out  1  FD-format bit seen recessive.
- typ_fr  out  2  0 = data frame, 1 = remote frame; updated at the RTR capture.
- dlc  out  4  captured DLC, raw value.
- data_byte  out  8  assembled payload byte.
- data_valid  out  1  one-clk pulse per completed payload byte.
- ack_seen  out  1  ACK slot sampled dominant in the last frame.
- frame_ok  out  1  one-clk pulse after the last EOF bit of an error-free frame.
- err  out  1  one-clk pulse when an error is detected.
- err_code  out  2  0 = stuff, 1 = CRC, 2 = form, 3 = FD-not-supported; valid when err pulses, held until the next error.

Behaviour:
- Reset: every output is 0; state = WAIT_IDLE; recessive-run counter = 0.
- All state changes happen on clk edges where sp = 1. Between strobes everything holds; pulses last exactly one clk.
- WAIT_IDLE: count consecutive recessive bits; a dominant bit clears the count. Reaching IDLE_BITS moves to IDLE.
- IDLE: a dominant bit is SOF. Clear frame_id, dlc, flags, ack_seen and CRC, then go to ID_A.
- Destuffing is active from SOF through the last CRC bit. It tracks the run length of equal bits (SOF counts as 1).
  - After 5 equal bits, the next bit is a stuff bit: it is discarded, the state does not advance and the CRC is not updated.
  - If the stuff bit equals the previous bit: err, code 0, go to WAIT_IDLE.
- Field states and transitions, with a bit counter reloaded at each field entry:
  - ID_A: 11 bits, MSB first into frame_id[28:18].
  - SRR_RTR: 1 bit.
  - IDE: 1 bit.
  - IDE = 0:
    - The SRR_RTR bit is rtr; typ_fr is set to rtr.
    - Next is R0_EDL: a recessive bit sets edl, pulses err with code 3, and goes to WAIT_IDLE.
    - A dominant bit goes to DLC.
  - IDE = 1:
    - ID_B: 18 bits into frame_id[17:0].
    - RTR_B: rtr and typ_fr set here.
    - R1_EDL: same FD rule as R0_EDL.
    - R0: 1 bit, value ignored.
    - Then DLC.
  - DLC: 4 bits. Data length n = 0 if rtr = 1, otherwise min(dlc, MAX_BYTES). If n = 0 go to CRC, else go to DATA.
  - DATA: 8*n bits. data_valid pulses on each 8th bit with the assembled byte.
  - CRC: 15 bits. Then CRC_DEL.
- CRC15 polynomial is 0x4599, init 0, computed over destuffed bits from SOF through the end of DATA. The received CRC is compared at the CRC-to-CRC_DEL transition; a mismatch sets an error flag that is reported at CRC_DEL.
- Post-CRC fields:
  - CRC_DEL: must be recessive, else err code 2. If the CRC mismatched, err code 1 instead (CRC takes priority).
  - ACK_SLOT: records ack_seen = !rx_bit.
  - ACK_DEL: must be recessive, else err code 2.
  - EOF: 7 bits, all recessive. Any dominant bit gives err code 2.
  - After the 7th EOF bit: frame_ok pulses and the block goes to IFS.
- IFS: 3 recessive bits, then IDLE. A dominant bit in the first 2 IFS bits gives err code 2. A dominant bit in the 3rd is treated as SOF.
- Every error path ends in WAIT_IDLE. Captured fields are not cleared on error.
- reset asserted mid-frame aborts immediately; no pulse is issued.
- sp held high on consecutive clks: each clk is one bit.

Decomposition:
- Shared package can_pkg holds:
  - the state enum;
  - err_code constants;
  - CRC15 polynomial 0x4599;
  - field lengths (11, 18, 4, 15, 7, 3);
  - TYPE_FR encodings (0 data, 1 remote).
- One sub-module, can_destuff: consumes sp and rx_bit and produces bit_valid, bit, and stuff_err. It is enabled by the sequencer between SOF and CRC end.

Test Plan:
- Base data frame, ID 0x123, DLC 2, data 0xAB 0xCD, correct CRC and stuffing, ACK dominant -> data_valid twice (0xAB, 0xCD); frame_id[28:18] = 0x123; typ_fr = 0; ack_seen = 1; frame_ok one pulse; err never asserts.
- Extended remote frame, ID 0x1ABCDE01, DLC 4 -> ide = 1, rtr = 1, typ_fr = 1, no data_valid, frame_ok pulses.
- Base frame with the 6th equal bit inside ID not inverted -> err with code 0 at that bit; state goes to WAIT_IDLE; frame_ok never pulses; IDLE is reached after 11 recessive bits.
- Base frame with one CRC bit flipped -> err code 1 at CRC_DEL.
- Dominant bit in EOF bit 4 -> err code 2.
- R0_EDL recessive -> edl = 1, err code 3.
- reset asserted during DATA byte 1 -> all outputs 0 on the next clk; WAIT_IDLE entered; a following valid frame decodes after 11 recessive bits.

Source files
------------

// File: rtl/can_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Shared definitions for the CAN receive sequencer:
//   - can_state_e   : field state encoding (WAIT_IDLE must stay 0, it is the
//                     reset state and the value reported on the state port)
//   - ERR_*         : err_code values
//   - CRC15_POLY    : CAN CRC15 generator polynomial
//   - LEN_*         : fixed field lengths in bits
//   - TYP_*         : typ_fr encodings
//   - crc15_step    : one-bit CRC15 update
// ---------------------------------------------------------------------------
package can_pkg;

  typedef enum logic [4:0] {
    ST_WAIT_IDLE = 5'd0,
    ST_IDLE      = 5'd1,
    ST_ID_A      = 5'd2,
    ST_SRR_RTR   = 5'd3,
    ST_IDE       = 5'd4,
    ST_R0_EDL    = 5'd5,
    ST_ID_B      = 5'd6,
    ST_RTR_B     = 5'd7,
    ST_R1_EDL    = 5'd8,
    ST_R0        = 5'd9,
    ST_DLC       = 5'd10,
    ST_DATA      = 5'd11,
    ST_CRC       = 5'd12,
    ST_CRC_DEL   = 5'd13,
    ST_ACK_SLOT  = 5'd14,
    ST_ACK_DEL   = 5'd15,
    ST_EOF       = 5'd16,
    ST_IFS       = 5'd17
  } can_state_e;

  localparam logic [1:0] ERR_STUFF = 2'd0;
  localparam logic [1:0] ERR_CRC   = 2'd1;
  localparam logic [1:0] ERR_FORM  = 2'd2;
  localparam logic [1:0] ERR_FD    = 2'd3;

  localparam logic [14:0] CRC15_POLY = 15'h4599;

  localparam int LEN_ID_A = 11;
  localparam int LEN_ID_B = 18;
  localparam int LEN_DLC  = 4;
  localparam int LEN_CRC  = 15;
  localparam int LEN_EOF  = 7;
  localparam int LEN_IFS  = 3;

  localparam logic [1:0] TYP_DATA   = 2'd0;
  localparam logic [1:0] TYP_REMOTE = 2'd1;

  // Shift one destuffed bit into the CRC register (MSB-first LFSR form).
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    crc15_step = {crc[13:0], 1'b0} ^ ((b ^ crc[14]) ? CRC15_POLY : 15'h0);
  endfunction

endpackage

// File: rtl/can_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// can_frame_sequencer_if
// Bus-bit input and decoded-frame outputs of the CAN receive sequencer.
//   master : bit source / frame consumer (drives sp, rx_bit)
//   slave  : the sequencer (drives all frame outputs)
// Signals: sp, rx_bit (in to sequencer); state, frame_id, ide, rtr, edl,
// typ_fr, dlc, data_byte, data_valid, ack_seen, frame_ok, err, err_code (out).
// ---------------------------------------------------------------------------
interface can_frame_sequencer_if;
  logic        sp;
  logic        rx_bit;
  logic [4:0]  state;
  logic [28:0] frame_id;
  logic        ide;
  logic        rtr;
  logic        edl;
  logic [1:0]  typ_fr;
  logic [3:0]  dlc;
  logic [7:0]  data_byte;
  logic        data_valid;
  logic        ack_seen;
  logic        frame_ok;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    output sp, rx_bit,
    input  state, frame_id, ide, rtr, edl, typ_fr, dlc, data_byte,
           data_valid, ack_seen, frame_ok, err, err_code
  );

  modport slave (
    input  sp, rx_bit,
    output state, frame_id, ide, rtr, edl, typ_fr, dlc, data_byte,
           data_valid, ack_seen, frame_ok, err, err_code
  );
endinterface

// File: rtl/can_destuff.sv
// ---------------------------------------------------------------------------
// can_destuff
// Removes CAN stuff bits. Tracks the run of equal bits; after five equal bits
// the next bit is a stuff bit: it is swallowed, and if it does not invert the
// run a stuff error is flagged.
// Ports:
//   clk, reset      : clock, async active-high reset
//   sp_i, rx_bit_i  : sample strobe and sampled bus bit
//   en_i            : destuffing active (fields between SOF and CRC end)
//   sof_i           : this strobe is SOF; restarts the run at length 1
//   bit_valid_o     : a data (non-stuff) bit is presented this clk
//   bit_o           : the data bit
//   stuff_err_o     : stuff bit did not invert the run
// ---------------------------------------------------------------------------
module can_destuff (
  input  logic clk,
  input  logic reset,
  input  logic sp_i,
  input  logic rx_bit_i,
  input  logic en_i,
  input  logic sof_i,
  output logic bit_valid_o,
  output logic bit_o,
  output logic stuff_err_o
);

  logic [2:0] run_q, run_d;
  logic       prev_q, prev_d;

  assign bit_o = rx_bit_i;

  always_comb begin
    run_d       = run_q;
    prev_d      = prev_q;
    bit_valid_o = 1'b0;
    stuff_err_o = 1'b0;
    if (sp_i) begin
      if (sof_i) begin
        run_d  = 3'd1;
        prev_d = rx_bit_i;
      end else if (en_i) begin
        if (run_q == 3'd5) begin
          // stuff slot: consumed here, a fresh run starts at the stuff bit
          stuff_err_o = (rx_bit_i == prev_q);
          run_d       = 3'd1;
          prev_d      = rx_bit_i;
        end else begin
          bit_valid_o = 1'b1;
          run_d       = (rx_bit_i == prev_q) ? run_q + 3'd1 : 3'd1;
          prev_d      = rx_bit_i;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/can_frame_sequencer.sv
// ---------------------------------------------------------------------------
// can_frame_sequencer
// Bit-level CAN receive controller. One bus bit per sp strobe; walks base and
// extended frame fields, captures ID/flags/DLC/payload, checks CRC15 and form,
// and pulses frame_ok or err.
// Ports:
//   clk, reset : clock, async active-high reset
//   bus        : can_frame_sequencer_if.slave (sp/rx_bit in, frame outputs)
// Parameters:
//   MAX_BYTES  : payload clamp for DLC > 8
//   IDLE_BITS  : recessive run that declares the bus idle
// ---------------------------------------------------------------------------
module can_frame_sequencer
  import can_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int IDLE_BITS = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  can_frame_sequencer_if.slave  bus
);

  localparam int         RUN_W = $clog2(IDLE_BITS + 1);
  localparam logic [3:0] MAX_N = 4'(MAX_BYTES);

  can_state_e        state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;       // bits left in current field, minus 1
  logic [RUN_W-1:0]  run_q, run_d;       // recessive run while waiting for idle
  logic [28:0]       id_q, id_d;
  logic              ide_q, ide_d, rtr_q, rtr_d, srr_q, srr_d, edl_q, edl_d;
  logic [1:0]        typ_q, typ_d;
  logic [3:0]        dlc_q, dlc_d;
  logic [7:0]        sr_q, sr_d, byte_q, byte_d;
  logic              dv_q, dv_d, ack_q, ack_d, ok_q, ok_d, err_q, err_d;
  logic [1:0]        ecode_q, ecode_d;
  logic [14:0]       crc_q, crc_d, crc_rx_q, crc_rx_d;
  logic              crc_bad_q, crc_bad_d;

  logic              ds_en, ds_sof, ds_valid, ds_bit, ds_err;
  logic              start, fail;
  logic [1:0]        fcode;
  logic [3:0]        dlc_full, nbytes;

  // SOF comes from IDLE or from a dominant third IFS bit.
  assign ds_en  = (state_q >= ST_ID_A) && (state_q <= ST_CRC);
  assign ds_sof = bus.sp && !bus.rx_bit &&
                  ((state_q == ST_IDLE) || (state_q == ST_IFS && cnt_q == '0));

  can_destuff u_destuff (
    .clk         (clk),
    .reset       (reset),
    .sp_i        (bus.sp),
    .rx_bit_i    (bus.rx_bit),
    .en_i        (ds_en),
    .sof_i       (ds_sof),
    .bit_valid_o (ds_valid),
    .bit_o       (ds_bit),
    .stuff_err_o (ds_err)
  );

  // Payload length once the last DLC bit arrives; remote frames carry none.
  assign dlc_full = {dlc_q[2:0], ds_bit};
  assign nbytes   = rtr_q ? 4'd0 : ((dlc_full > MAX_N) ? MAX_N : dlc_full);

  always_comb begin
    state_d   = state_q;   cnt_d    = cnt_q;    run_d   = run_q;
    id_d      = id_q;      ide_d    = ide_q;    rtr_d   = rtr_q;
    srr_d     = srr_q;     edl_d    = edl_q;    typ_d   = typ_q;
    dlc_d     = dlc_q;     sr_d     = sr_q;     byte_d  = byte_q;
    ack_d     = ack_q;     ecode_d  = ecode_q;  crc_d   = crc_q;
    crc_rx_d  = crc_rx_q;  crc_bad_d = crc_bad_q;
    dv_d      = 1'b0;      ok_d     = 1'b0;     err_d   = 1'b0;
    start     = 1'b0;      fail     = 1'b0;     fcode   = ERR_FORM;

    case (state_q)
      ST_WAIT_IDLE: if (bus.sp) begin
        if (!bus.rx_bit) run_d = '0;
        else if (run_q == RUN_W'(IDLE_BITS - 1)) begin
          run_d   = '0;
          state_d = ST_IDLE;
        end else run_d = run_q + 1'b1;
      end

      ST_IDLE: start = ds_sof;

      ST_ID_A, ST_SRR_RTR, ST_IDE, ST_R0_EDL, ST_ID_B, ST_RTR_B,
      ST_R1_EDL, ST_R0, ST_DLC, ST_DATA, ST_CRC: begin
        if (ds_err) begin
          fail  = 1'b1;
          fcode = ERR_STUFF;
        end else if (ds_valid) begin
          cnt_d = cnt_q - 1'b1;
          if (state_q != ST_CRC) crc_d = crc15_step(crc_q, ds_bit);
          case (state_q)
            ST_ID_A: begin
              id_d[28:18] = {id_q[27:18], ds_bit};
              if (cnt_q == '0) state_d = ST_SRR_RTR;
            end
            ST_SRR_RTR: begin
              srr_d   = ds_bit;
              state_d = ST_IDE;
            end
            ST_IDE: begin
              ide_d = ds_bit;
              if (ds_bit) begin
                state_d = ST_ID_B;
                cnt_d   = 7'(LEN_ID_B - 1);
              end else begin
                // base frame: the bit after ID_A was RTR
                rtr_d   = srr_q;
                typ_d   = srr_q ? TYP_REMOTE : TYP_DATA;
                state_d = ST_R0_EDL;
              end
            end
            ST_ID_B: begin
              id_d[17:0] = {id_q[16:0], ds_bit};
              if (cnt_q == '0) state_d = ST_RTR_B;
            end
            ST_RTR_B: begin
              rtr_d   = ds_bit;
              typ_d   = ds_bit ? TYP_REMOTE : TYP_DATA;
              state_d = ST_R1_EDL;
            end
            ST_R0_EDL, ST_R1_EDL: begin
              if (ds_bit) begin
                edl_d = 1'b1;
                fail  = 1'b1;
                fcode = ERR_FD;
              end else if (state_q == ST_R0_EDL) begin
                state_d = ST_DLC;
                cnt_d   = 7'(LEN_DLC - 1);
              end else state_d = ST_R0;
            end
            ST_R0: begin
              state_d = ST_DLC;
              cnt_d   = 7'(LEN_DLC - 1);
            end
            ST_DLC: begin
              dlc_d = dlc_full;
              if (cnt_q == '0) begin
                if (nbytes == 4'd0) begin
                  state_d = ST_CRC;
                  cnt_d   = 7'(LEN_CRC - 1);
                end else begin
                  state_d = ST_DATA;
                  cnt_d   = {nbytes, 3'b000} - 7'd1;
                end
              end
            end
            ST_DATA: begin
              sr_d = {sr_q[6:0], ds_bit};
              // counter counts down from 8n-1, so byte ends land on multiples of 8
              if (cnt_q[2:0] == 3'd0) begin
                byte_d = {sr_q[6:0], ds_bit};
                dv_d   = 1'b1;
              end
              if (cnt_q == '0) begin
                state_d = ST_CRC;
                cnt_d   = 7'(LEN_CRC - 1);
              end
            end
            ST_CRC: begin
              crc_rx_d = {crc_rx_q[13:0], ds_bit};
              if (cnt_q == '0) begin
                crc_bad_d = ({crc_rx_q[13:0], ds_bit} != crc_q);
                state_d   = ST_CRC_DEL;
              end
            end
            default: ;
          endcase
        end
      end

      ST_CRC_DEL: if (bus.sp) begin
        if (crc_bad_q) begin
          fail  = 1'b1;
          fcode = ERR_CRC;
        end else if (!bus.rx_bit) fail = 1'b1;
        else state_d = ST_ACK_SLOT;
      end

      ST_ACK_SLOT: if (bus.sp) begin
        ack_d   = !bus.rx_bit;
        state_d = ST_ACK_DEL;
      end

      ST_ACK_DEL: if (bus.sp) begin
        if (!bus.rx_bit) fail = 1'b1;
        else begin
          state_d = ST_EOF;
          cnt_d   = 7'(LEN_EOF - 1);
        end
      end

      ST_EOF: if (bus.sp) begin
        if (!bus.rx_bit) fail = 1'b1;
        else if (cnt_q == '0) begin
          ok_d    = 1'b1;
          state_d = ST_IFS;
          cnt_d   = 7'(LEN_IFS - 1);
        end else cnt_d = cnt_q - 1'b1;
      end

      ST_IFS: if (bus.sp) begin
        if (!bus.rx_bit) begin
          if (cnt_q != '0) fail = 1'b1;
          else start = 1'b1;
        end else if (cnt_q == '0) state_d = ST_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end

      default: state_d = ST_WAIT_IDLE;
    endcase

    if (start) begin
      id_d      = '0;   dlc_d = '0;   ide_d = 1'b0;  rtr_d = 1'b0;
      srr_d     = 1'b0; edl_d = 1'b0; typ_d = TYP_DATA;
      ack_d     = 1'b0; crc_d = '0;   crc_bad_d = 1'b0;
      state_d   = ST_ID_A;
      cnt_d     = 7'(LEN_ID_A - 1);
    end

    if (fail) begin
      err_d   = 1'b1;
      ecode_d = fcode;
      state_d = ST_WAIT_IDLE;
      run_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT_IDLE; cnt_q <= '0;   run_q <= '0;
      id_q    <= '0;   ide_q  <= 1'b0; rtr_q <= 1'b0; srr_q <= 1'b0;
      edl_q   <= 1'b0; typ_q  <= '0;   dlc_q <= '0;   sr_q  <= '0;
      byte_q  <= '0;   dv_q   <= 1'b0; ack_q <= 1'b0; ok_q  <= 1'b0;
      err_q   <= 1'b0; ecode_q <= '0;  crc_q <= '0;   crc_rx_q <= '0;
      crc_bad_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d;   run_q <= run_d;
      id_q    <= id_d;    ide_q <= ide_d;   rtr_q <= rtr_d; srr_q <= srr_d;
      edl_q   <= edl_d;   typ_q <= typ_d;   dlc_q <= dlc_d; sr_q  <= sr_d;
      byte_q  <= byte_d;  dv_q  <= dv_d;    ack_q <= ack_d; ok_q  <= ok_d;
      err_q   <= err_d;   ecode_q <= ecode_d; crc_q <= crc_d; crc_rx_q <= crc_rx_d;
      crc_bad_q <= crc_bad_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.frame_id   = id_q;
  assign bus.ide        = ide_q;
  assign bus.rtr        = rtr_q;
  assign bus.edl        = edl_q;
  assign bus.typ_fr     = typ_q;
  assign bus.dlc        = dlc_q;
  assign bus.data_byte  = byte_q;
  assign bus.data_valid = dv_q;
  assign bus.ack_seen   = ack_q;
  assign bus.frame_ok   = ok_q;
  assign bus.err        = err_q;
  assign bus.err_code   = ecode_q;

endmodule

// File: tb/tb_can_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_can_frame_sequencer
// Directed frames with hand-chosen expected IDs, flags, payload bytes and
// error codes. Stimulus pushes expected events into a queue; a monitor pops
// and compares on every data_valid / frame_ok / err pulse.
// ---------------------------------------------------------------------------
module tb_can_frame_sequencer;

  localparam int EV_DV = 0, EV_OK = 1, EV_ERR = 2;
  localparam logic [4:0] S_WAIT = 5'd0, S_IDLE = 5'd1;

  typedef struct {
    int          kind;
    logic [7:0]  val;
    logic [28:0] id;
    logic        ide, rtr, ack;
    logic [1:0]  typ;
    logic [3:0]  dlc;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  can_frame_sequencer_if bif();

  can_frame_sequencer #(.MAX_BYTES(8), .IDLE_BITS(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  ev_t exp_q[$];

  logic [7:0] pay [0:7];
  bit fq[$];
  int first_stuff, data_start;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic exp_dv(input logic [7:0] b);
    ev_t e;
    e = '{kind: EV_DV, val: b, id: '0, ide: 0, rtr: 0, ack: 0, typ: '0, dlc: '0};
    exp_q.push_back(e);
  endtask

  task automatic exp_ok(input logic [28:0] id, input logic ide, input logic rtr,
                        input logic [1:0] typ, input logic ack, input logic [3:0] dlc);
    ev_t e;
    e = '{kind: EV_OK, val: '0, id: id, ide: ide, rtr: rtr, ack: ack, typ: typ, dlc: dlc};
    exp_q.push_back(e);
  endtask

  task automatic exp_err(input logic [1:0] code);
    ev_t e;
    e = '{kind: EV_ERR, val: {6'd0, code}, id: '0, ide: 0, rtr: 0, ack: 0, typ: '0, dlc: '0};
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d want none", kind);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind == e.kind) begin
      case (kind)
        EV_DV:  chk("data_byte", {24'd0, bif.data_byte}, {24'd0, e.val});
        EV_OK: begin
          chk("frame_id", {3'd0, bif.frame_id}, {3'd0, e.id});
          chk("ide", {31'd0, bif.ide}, {31'd0, e.ide});
          chk("rtr", {31'd0, bif.rtr}, {31'd0, e.rtr});
          chk("typ_fr", {30'd0, bif.typ_fr}, {30'd0, e.typ});
          chk("ack_seen", {31'd0, bif.ack_seen}, {31'd0, e.ack});
          chk("dlc", {28'd0, bif.dlc}, {28'd0, e.dlc});
        end
        default: chk("err_code", {30'd0, bif.err_code}, {24'd0, e.val});
      endcase
    end
  endtask

  // Monitor: outputs change on posedge, sampled on negedge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.data_valid) take(EV_DV);
      if (bif.frame_ok)   take(EV_OK);
      if (bif.err)        take(EV_ERR);
    end
  end

  // Build the on-wire bit sequence of a frame into fq (stuffed, plus tail).
  task automatic build(input logic [28:0] id, input bit ext, input bit rtr, input bit fdbit,
                       input logic [3:0] dlc, input int nb, input int crc_flip, input int eof_dom);
    bit u[$];
    logic [14:0] c;
    bit fb, prev;
    int run, data_u;
    u.push_back(1'b0);
    for (int i = 10; i >= 0; i--) u.push_back(id[18+i]);
    if (ext) begin
      u.push_back(1'b1); u.push_back(1'b1);
      for (int i = 17; i >= 0; i--) u.push_back(id[i]);
      u.push_back(rtr); u.push_back(fdbit); u.push_back(1'b0);
    end else begin
      u.push_back(rtr); u.push_back(1'b0); u.push_back(fdbit);
    end
    for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
    data_u = u.size();
    for (int k = 0; k < nb; k++)
      for (int i = 7; i >= 0; i--) u.push_back(pay[k][i]);
    c = '0;
    for (int j = 0; j < u.size(); j++) begin
      fb = u[j] ^ c[14];
      c  = {c[13:0], 1'b0};
      if (fb) c = c ^ 15'h4599;
    end
    if (crc_flip >= 0) c[crc_flip] = ~c[crc_flip];
    for (int i = 14; i >= 0; i--) u.push_back(c[i]);
    fq.delete();
    run = 0; prev = 1'b0; first_stuff = -1; data_start = -1;
    for (int j = 0; j < u.size(); j++) begin
      if (j == data_u) data_start = fq.size();
      fq.push_back(u[j]);
      if (j > 0 && u[j] == prev) run++;
      else run = 1;
      prev = u[j];
      if (run == 5 && j != u.size() - 1) begin
        fq.push_back(!u[j]);
        if (first_stuff < 0) first_stuff = fq.size() - 1;
        prev = !u[j];
        run  = 1;
      end
    end
    fq.push_back(1'b1);                 // CRC delimiter
    fq.push_back(1'b0);                 // ACK slot, acknowledged
    fq.push_back(1'b1);                 // ACK delimiter
    for (int i = 0; i < 7; i++) fq.push_back(i == eof_dom ? 1'b0 : 1'b1);
    for (int i = 0; i < 3; i++) fq.push_back(1'b1);
  endtask

  // Called at a negedge; returns at the negedge after the bit is consumed.
  task automatic send_bit(input bit b, input int gap);
    bif.sp = 1'b1; bif.rx_bit = b;
    @(negedge clk);
    bif.sp = 1'b0; bif.rx_bit = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int nbits, input int gap);
    for (int i = 0; i < nbits && i < fq.size(); i++) send_bit(fq[i], gap);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, {27'd0, bif.state}, 32'd0);
    chk({tag, "_frame_id"}, {3'd0, bif.frame_id}, 32'd0);
    chk({tag, "_flags"}, {26'd0, bif.ide, bif.rtr, bif.edl, bif.ack_seen, bif.typ_fr}, 32'd0);
    chk({tag, "_dlc_byte"}, {20'd0, bif.dlc, bif.data_byte}, 32'd0);
    chk({tag, "_pulses"}, {27'd0, bif.data_valid, bif.frame_ok, bif.err, bif.err_code}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bif.sp = 1'b0; bif.rx_bit = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Power-up idle detection
    idle_bits(10);
    chk("pre_idle_state", {27'd0, bif.state}, {27'd0, S_WAIT});
    idle_bits(1);
    chk("idle_state", {27'd0, bif.state}, {27'd0, S_IDLE});

    // Base data frame 0x123, 0xAB 0xCD
    pay[0] = 8'hAB; pay[1] = 8'hCD;
    build(29'h123 << 18, 0, 0, 0, 4'd2, 2, -1, -1);
    exp_dv(8'hAB); exp_dv(8'hCD); exp_ok(29'h123 << 18, 0, 0, 2'd0, 1, 4'd2);
    send_frame(fq.size(), 1);
    chk("base_end_state", {27'd0, bif.state}, {27'd0, S_IDLE});

    // Extended remote frame, back-to-back strobes
    build(29'h1ABCDE01, 1, 1, 0, 4'd4, 0, -1, -1);
    exp_ok(29'h1ABCDE01, 1, 1, 2'd1, 1, 4'd4);
    send_frame(fq.size(), 0);
    @(negedge clk);
    chk("ext_end_state", {27'd0, bif.state}, {27'd0, S_IDLE});

    // Stuff error: first stuff bit (inside ID of ID=0) not inverted
    build(29'd0, 0, 0, 0, 4'd0, 0, -1, -1);
    fq[first_stuff] = fq[first_stuff-1];
    exp_err(2'd0);
    send_frame(first_stuff + 1, 1);
    chk("stuff_err_state", {27'd0, bif.state}, {27'd0, S_WAIT});
    idle_bits(10);
    chk("stuff_wait_state", {27'd0, bif.state}, {27'd0, S_WAIT});
    idle_bits(1);
    chk("stuff_idle_state", {27'd0, bif.state}, {27'd0, S_IDLE});

    // CRC bit flipped
    build(29'h123 << 18, 0, 0, 0, 4'd2, 2, 3, -1);
    exp_dv(8'hAB); exp_dv(8'hCD); exp_err(2'd1);
    send_frame(fq.size(), 1);
    idle_bits(11);
    chk("crc_idle_state", {27'd0, bif.state}, {27'd0, S_IDLE});

    // Dominant 4th EOF bit
    build(29'h123 << 18, 0, 0, 0, 4'd2, 2, -1, 3);
    exp_dv(8'hAB); exp_dv(8'hCD); exp_err(2'd2);
    send_frame(fq.size(), 1);
    idle_bits(11);
    chk("eof_idle_state", {27'd0, bif.state}, {27'd0, S_IDLE});

    // FD format bit recessive
    build(29'h123 << 18, 0, 0, 1, 4'd2, 2, -1, -1);
    exp_err(2'd3);
    send_frame(fq.size(), 1);
    chk("fd_edl", {31'd0, bif.edl}, 32'd1);
    idle_bits(11);
    chk("fd_idle_state", {27'd0, bif.state}, {27'd0, S_IDLE});

    // Reset inside first data byte, then a clean frame
    build(29'h123 << 18, 0, 0, 0, 4'd2, 2, -1, -1);
    send_frame(data_start + 3, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    reset = 1'b0;
    @(negedge clk);
    idle_bits(11);
    chk("post_reset_idle", {27'd0, bif.state}, {27'd0, S_IDLE});
    exp_dv(8'hAB); exp_dv(8'hCD); exp_ok(29'h123 << 18, 0, 0, 2'd0, 1, 4'd2);
    send_frame(fq.size(), 1);
    repeat (4) @(negedge clk);
    chk("final_state", {27'd0, bif.state}, {27'd0, S_IDLE});
    chk("pending_events", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
